// File: rtl/bram_block_store_pkg.sv
// Shared command encodings and width helper for the RAM-client responders
// (this BRAM block store and the SDRAM controller use the same contract).
package bram_block_store_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RFETCH,
    ST_READ
  } state_e;

  localparam int CMD_BLOCK_W = 21;
  localparam int DATA_W      = 16;

  // Index width for n entries; never zero so single-entry cases stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_block_store_sp.sv
// Single-port synchronous-read RAM, one cycle read latency, read-first.
module bram_sp #(
  parameter int Depth = 64,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bram_block_store.sv
// Block-oriented RAM responder: streams whole blocks in/out of a BRAM using
// the same command/ready/trigger handshake as the SDRAM controller.
module bram_block_store
  import bram_block_store_pkg::*;
#(
  parameter int BlockSize  = 16,
  parameter int BlockCount = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [1:0]             cmd,
  input  logic [CMD_BLOCK_W-1:0] cmd_block,
  output logic                   write_ready,
  input  logic                   write_trigger,
  input  logic [DATA_W-1:0]      write_data,
  output logic                   read_ready,
  input  logic                   read_trigger,
  output logic [DATA_W-1:0]      read_data
);

  localparam int Depth = BlockSize * BlockCount;
  localparam int IW    = idx_w(BlockSize);
  localparam int BW    = idx_w(BlockCount);
  localparam int AW    = idx_w(Depth);
  localparam logic [IW-1:0] One  = IW'(1);
  localparam logic [IW-1:0] Last = IW'(BlockSize - 1);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [BW-1:0]   blk_q;
  logic            wr_rdy_q, rd_rdy_q;
  logic            live_q;
  cmd_e            cmd_s;
  logic [BW-1:0]   blk_sel;
  logic            consume, accept, last;
  logic [IW-1:0]   idx_sel;
  logic [AW-1:0]   addr;
  logic [DATA_W-1:0] ram_rdata;
  logic            unused_cmd_block;

  assign cmd_s   = cmd_e'(cmd);
  // Block index is taken modulo BlockCount by dropping the high bits.
  assign blk_sel = (BlockCount == 1) ? '0 : BW'(cmd_block);
  assign unused_cmd_block = ^cmd_block;

  assign last    = (idx_q == Last);
  assign consume = rd_rdy_q && read_trigger && (cmd_s == CMD_NONE);
  assign accept  = wr_rdy_q && write_trigger && (cmd_s == CMD_NONE);
  // Prefetch the next word while one is consumed so reads stream bubble-free.
  assign idx_sel = consume ? idx_q + One : idx_q;
  assign addr    = (AW'(blk_q) << IW) | AW'(idx_sel);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      blk_q    <= '0;
      wr_rdy_q <= 1'b0;
      rd_rdy_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      // First edge after reset release ignores commands.
      live_q <= 1'b1;
      if (live_q) begin
        case (cmd_s)
          CMD_READ: begin
            state_q  <= ST_RFETCH;
            blk_q    <= blk_sel;
            idx_q    <= '0;
            wr_rdy_q <= 1'b0;
            rd_rdy_q <= 1'b0;
          end
          CMD_WRITE: begin
            state_q  <= ST_WRITE;
            blk_q    <= blk_sel;
            idx_q    <= '0;
            wr_rdy_q <= 1'b1;
            rd_rdy_q <= 1'b0;
          end
          CMD_STOP: begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            wr_rdy_q <= 1'b0;
            rd_rdy_q <= 1'b0;
          end
          default: begin
            case (state_q)
              ST_WRITE: if (accept) begin
                idx_q <= idx_q + One;
                if (last) begin
                  state_q  <= ST_IDLE;
                  wr_rdy_q <= 1'b0;
                end
              end
              ST_RFETCH: begin
                state_q  <= ST_READ;
                rd_rdy_q <= 1'b1;
              end
              ST_READ: if (consume) begin
                idx_q <= idx_q + One;
                if (last) begin
                  state_q  <= ST_IDLE;
                  rd_rdy_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

  bram_sp #(.Depth(Depth), .AW(AW), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (addr),
    .wdata (write_data),
    .rdata (ram_rdata)
  );

  assign write_ready = wr_rdy_q;
  assign read_ready  = rd_rdy_q;
  assign read_data   = rd_rdy_q ? ram_rdata : '0;

endmodule

// File: tb/tb_bram_block_store.sv
// Self-checking bench for bram_block_store: directed scenarios plus random
// block traffic checked against a flat array model of the memory.
module tb_bram_block_store;

  localparam int BS = 16;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [20:0] cmd_block = '0;
  logic        write_ready, read_ready;
  logic        write_trigger = 1'b0, read_trigger = 1'b0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] mem_m [BS*BC];
  bit          full_m [BC];

  bram_block_store #(.BlockSize(BS), .BlockCount(BC)) dut (
    .clk(clk), .rst_(rst_), .cmd(cmd), .cmd_block(cmd_block),
    .write_ready(write_ready), .write_trigger(write_trigger), .write_data(write_data),
    .read_ready(read_ready), .read_trigger(read_trigger), .read_data(read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int maddr(input logic [20:0] b, input int i);
    return int'(b % BC) * BS + i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [20:0] b);
    cmd = c;
    cmd_block = b;
    tick();
    cmd = 2'd0;
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Writes nwords words; pat selects data 3^i, gaps randomises write_trigger.
  task automatic write_block(input logic [20:0] b, input int nwords, input bit pat,
                             input bit gaps, input string nm);
    int acc = 0;
    int cyc = 0;
    issue(2'd2, b);
    while (acc < nwords && cyc < 400) begin
      chk_bit({nm, " write_ready"}, write_ready, 1'b1);
      write_trigger = gaps ? 1'($urandom % 2) : 1'b1;
      write_data = pat ? 16'(3 ^ acc) : 16'($urandom);
      if (write_trigger) begin
        mem_m[maddr(b, acc)] = write_data;
        acc++;
      end
      tick();
      cyc++;
    end
    write_trigger = 1'b0;
    if (acc < nwords) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: accepted %0d required %0d", nm, acc, nwords);
    end
    if (nwords == BS) begin
      chk_bit({nm, " write_ready after block"}, write_ready, 1'b0);
      full_m[b % BC] = 1'b1;
    end
  endtask

  // mode 0: trigger held, 1: toggled 1,0,1,0..., 2: random. Stops early if nwords<BS.
  task automatic read_block(input logic [20:0] b, input int nwords, input int mode,
                            input bit stop_after, input string nm);
    int idx = 0;
    int cyc = 0;
    logic [15:0] exp;
    issue(2'd1, b);
    chk_bit({nm, " read_ready in fetch"}, read_ready, 1'b0);
    tick();
    while (idx < nwords && cyc < 400) begin
      chk_bit({nm, " read_ready"}, read_ready, 1'b1);
      exp = mem_m[maddr(b, idx)];
      n_cmp++;
      if (read_data !== exp) begin
        n_bad++;
        $display("FAIL %s data word %0d: got %h expected %h", nm, idx, read_data, exp);
      end
      case (mode)
        0: read_trigger = 1'b1;
        1: read_trigger = (cyc % 2 == 0);
        default: read_trigger = 1'($urandom % 2);
      endcase
      if (read_trigger) idx++;
      if (idx < nwords || !stop_after) tick();
      cyc++;
    end
    read_trigger = 1'b0;
    if (idx < nwords) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: consumed %0d required %0d", nm, idx, nwords);
    end
    if (nwords == BS) chk_bit({nm, " read_ready after block"}, read_ready, 1'b0);
    else if (stop_after) begin
      cmd = 2'd3;
      tick();
      cmd = 2'd0;
      chk_bit({nm, " read_ready after stop"}, read_ready, 1'b0);
    end
  endtask

  task automatic test_reset();
    #1;
    chk_bit("reset write_ready", write_ready, 1'b0);
    chk_bit("reset read_ready", read_ready, 1'b0);
    n_cmp++;
    if (read_data !== 16'h0) begin
      n_bad++;
      $display("FAIL reset read_data: got %h expected 0000", read_data);
    end
    tick();
    rst_ = 1'b1;
    cmd = 2'd2;
    tick();
    cmd = 2'd0;
    chk_bit("cmd at reset release ignored", write_ready, 1'b0);
  endtask

  task automatic test_write_read();
    write_block(21'd3, BS, 1'b1, 1'b0, "wr blk3");
    read_block(21'd3, BS, 0, 1'b0, "rd blk3");
  endtask

  task automatic test_alias();
    write_block(21'd5, BS, 1'b0, 1'b0, "wr blk5");
    read_block(21'd1, BS, 0, 1'b0, "rd blk1 alias");
  endtask

  task automatic test_toggle();
    read_block(21'd3, BS, 1, 1'b0, "rd toggle");
  endtask

  task automatic test_abort();
    write_block(21'd2, 7, 1'b0, 1'b0, "wr blk2 partial");
    write_block(21'd0, BS, 1'b0, 1'b0, "wr blk0 after abort");
    read_block(21'd2, 7, 0, 1'b1, "rd blk2 partial");
    read_block(21'd0, BS, 2, 1'b0, "rd blk0");
  endtask

  task automatic test_reset_mid_read();
    int idx = 0;
    issue(2'd1, 21'd0);
    tick();
    read_trigger = 1'b1;
    while (idx < 9) begin
      tick();
      idx++;
    end
    read_trigger = 1'b0;
    chk_bit("mid-read ready before reset", read_ready, 1'b1);
    rst_ = 1'b0;
    #1;
    chk_bit("mid-read reset read_ready", read_ready, 1'b0);
    n_cmp++;
    if (read_data !== 16'h0) begin
      n_bad++;
      $display("FAIL mid-read reset read_data: got %h expected 0000", read_data);
    end
    tick();
    tick();
    rst_ = 1'b1;
    tick();
    read_block(21'd0, BS, 0, 1'b0, "rd blk0 after reset");
  endtask

  task automatic test_stop();
    write_block(21'd1, 4, 1'b0, 1'b0, "wr blk1 before stop");
    issue(2'd3, 21'd0);
    for (int i = 0; i < 4; i++) begin
      chk_bit("write_ready after stop", write_ready, 1'b0);
      write_trigger = 1'b1;
      write_data = 16'hDEAD;
      tick();
    end
    write_trigger = 1'b0;
    read_block(21'd1, BS, 0, 1'b0, "rd blk1 after stop");
  endtask

  task automatic test_random();
    logic [20:0] b;
    int r;
    for (int it = 0; it < 8; it++) begin
      b = 21'($urandom);
      write_block(b, BS, 1'b0, 1'b1, "rand wr");
      do r = int'($urandom % BC); while (!full_m[r]);
      read_block(21'($urandom) & ~21'(BC - 1) | 21'(r), BS, 2, 1'b0, "rand rd");
    end
  endtask

  initial begin
    for (int i = 0; i < BC; i++) full_m[i] = 1'b0;
    test_reset();
    test_write_read();
    test_alias();
    test_toggle();
    test_abort();
    test_reset_mid_read();
    test_stop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
